// File: rtl/cdb_broadcast_pkg.sv
// Shared CDB types, sizes and pointer helper for cdb_broadcast.
// Optional same-cycle bypass is enabled with CDB_BYPASS_EN.
package cdb_broadcast_pkg;

  localparam int N_FU         = 8;
  localparam int CDB_WIDTH    = 3;
  localparam int ROB_IDX_BITS = 5;
  localparam int PTR_W        = $clog2(N_FU);

  typedef struct packed {
    logic [ROB_IDX_BITS-1:0] tag;
    logic [31:0]             value;
  } fu_cdb_packet_t;

  typedef struct packed {
    logic                    valid;
    logic [ROB_IDX_BITS-1:0] tag;
    logic [31:0]             value;
  } cdb_lane_t;

  typedef cdb_lane_t [CDB_WIDTH-1:0] cdb_rs_packet_t;

  function automatic logic [PTR_W-1:0] ptr_inc(
    input logic [PTR_W-1:0] p
  );
    if (p == PTR_W'(N_FU - 1)) return '0;
    return p + 1'b1;
  endfunction

endpackage

// File: rtl/cdb_rr_sel.sv
// Combinational round-robin selector: grants up to CDB_WIDTH
// requesters starting at the pointer, one one-hot vector per lane.
module cdb_rr_sel
  import cdb_broadcast_pkg::*;
(
  input  logic [N_FU-1:0]                i_req,
  input  logic [PTR_W-1:0]               i_rr_ptr,
  output logic [CDB_WIDTH-1:0][N_FU-1:0] o_grant,
  output logic [PTR_W-1:0]               o_next_ptr
);

  always_comb begin
    logic [PTR_W-1:0]                 w_idx;
    logic [$clog2(CDB_WIDTH+1)-1:0]   w_cnt;
    o_grant    = '0;
    o_next_ptr = i_rr_ptr;
    w_idx      = i_rr_ptr;
    w_cnt      = '0;
    for (int k = 0; k < N_FU; k++) begin
      if (i_req[w_idx] && (int'(w_cnt) < CDB_WIDTH)) begin
        o_grant[w_cnt][w_idx] = 1'b1;
        o_next_ptr            = ptr_inc(w_idx);
        w_cnt                 = w_cnt + 1'b1;
      end
      w_idx = ptr_inc(w_idx);
    end
  end

endmodule

// File: rtl/cdb_broadcast.sv
// CDB producer: per-FU holding registers, round-robin onto CDB lanes.
// Define CDB_BYPASS_EN to let empty-hold FUs compete in their done cycle.
module cdb_broadcast
  import cdb_broadcast_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       squash_flag,
  input  logic [N_FU-1:0]            fu_done,
  input  fu_cdb_packet_t [N_FU-1:0]  fu_packet,
  output logic [N_FU-1:0]            fu_stall,
  output cdb_rs_packet_t             cdb_packet_out
);

  logic [N_FU-1:0]            r_hold_valid;
  fu_cdb_packet_t [N_FU-1:0]  r_hold_pkt;
  logic [PTR_W-1:0]           r_rr_ptr;
  cdb_rs_packet_t             r_cdb;

  logic [N_FU-1:0]                w_req;
  logic [N_FU-1:0]                w_gnt_any;
  logic [N_FU-1:0]                w_byp_gnt;
  logic [N_FU-1:0]                w_accept;
  logic [N_FU-1:0]                w_write;
  logic [CDB_WIDTH-1:0][N_FU-1:0] w_grant;
  logic [PTR_W-1:0]               w_next_ptr;
  fu_cdb_packet_t [N_FU-1:0]      w_src;
  cdb_rs_packet_t                 w_lanes;

`ifdef CDB_BYPASS_EN
  assign w_req     = r_hold_valid | (fu_done & ~r_hold_valid);
  assign w_byp_gnt = w_gnt_any & ~r_hold_valid;
`else
  assign w_req     = r_hold_valid;
  assign w_byp_gnt = '0;
`endif

  cdb_rr_sel u_sel (
    .i_req      (w_req),
    .i_rr_ptr   (r_rr_ptr),
    .o_grant    (w_grant),
    .o_next_ptr (w_next_ptr)
  );

  always_comb begin
    w_gnt_any = '0;
    for (int l = 0; l < CDB_WIDTH; l++)
      w_gnt_any = w_gnt_any | w_grant[l];
  end

  always_comb begin
    w_src = '0;
    for (int i = 0; i < N_FU; i++)
      w_src[i] = r_hold_valid[i] ? r_hold_pkt[i] : fu_packet[i];
  end

  // Reset and squash both present an unstalled bus to the FUs.
  assign fu_stall = (reset | squash_flag) ? '0
                  : (r_hold_valid & ~w_gnt_any);
  assign w_accept = fu_done & ~fu_stall;
  assign w_write  = w_accept & ~w_byp_gnt;

  always_comb begin
    w_lanes = '0;
    for (int l = 0; l < CDB_WIDTH; l++) begin
      for (int i = 0; i < N_FU; i++) begin
        if (w_grant[l][i]) begin
          w_lanes[l].valid = 1'b1;
          w_lanes[l].tag   = w_src[i].tag;
          w_lanes[l].value = w_src[i].value;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_hold_valid <= '0;
      r_rr_ptr     <= '0;
      r_cdb        <= '0;
    end else if (squash_flag) begin
      r_hold_valid <= '0;
      r_cdb        <= '0;
    end else begin
      r_hold_valid <= (r_hold_valid & ~w_gnt_any) | w_write;
      r_rr_ptr     <= w_next_ptr;
      r_cdb        <= w_lanes;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < N_FU; i++)
      if (w_write[i]) r_hold_pkt[i] <= fu_packet[i];
  end

  assign cdb_packet_out = r_cdb;

endmodule
